text_render_ctrl: RTL and testbench
===================================

Name: text_render_ctrl

Overview:
- Sequencing controller for the on-screen "ISA" text overlay.
- Takes pixel coordinates from the VGA sync generator and computes the character cell and glyph row.
- Drives the synchronous 64x8 font ROM (1-cycle read latency) and aligns the returned glyph bits with delayed pixel sideband through a fixed pipeline.
- Owns text colour configuration (frame-synchronous colour load) and an optional frame-based blink.

Parameters:
- X0, 303, left pixel column of first glyph
- Y0, 232, top pixel row of glyph band
- CHAR_W, 8, glyph width in pixels (fixed 8; ROM word width)
- GAP, 4, blank pixels between glyphs
- CHAR_H, 16, glyph height in rows (fixed 16; ROM row field 4 bits)
- STR_LEN, 3, number of glyphs; glyph i uses char code i+1 (1=I, 2=S, 3=A)
- BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
- clk, input, 1, system clock
- rst, input, 1, reset; synchronous, active-high
- video_on, input, 1, visible-area flag from sync generator
- pixel_x, input, 10, current pixel column
- pixel_y, input, 10, current pixel row
- sw_rgb, input, 3, colour switches {blue,green,red} = {sw[2],sw[1],sw[0]}
- cfg_load, input, 1, single-cycle pulse: request colour update
- blink_en, input, 1, level; enables text blink
- rom_addr, output, 6, {char_code[1:0], row[3:0]} to font ROM
- rom_data, input, 8, ROM word; bit 7 = leftmost pixel
- rgb_text, output, 3, pixel colour {red,green,blue}
- frame_start, output, 1, one-cycle pulse at first cycle of pixel (0,0)
- cfg_pending, output, 1, high while a colour load waits for frame_start

Behaviour:
- Reset values: rom_addr=0, rgb_text=0, frame_start=0, cfg_pending=0, active colour=3'b111, pending colour=0, FSM=IDLE, frame counter=0, blink_phase=0, all pipeline valid/on flags=0.
- Geometry, combinational on inputs:
  - dx = pixel_x - X0
  - in_band when Y0 <= pixel_y <= Y0+CHAR_H-1
  - in_span when pixel_x >= X0 and dx < STR_LEN*(CHAR_W+GAP)
  - idx = dx / (CHAR_W+GAP); col = dx mod (CHAR_W+GAP)
  - glyph_on = in_band & in_span & (col < CHAR_W)
  - char_code = glyph_on ? idx+1 : 0
  - row = (pixel_y - Y0)[3:0] when in_band, else 0
  - Defaults give I at x 303-310, S at 315-322, A at 327-334, rows 232-247.
- Pipeline: advances every clk, no stall.
  - Edge t: rom_addr <= {char_code,row}. Stage-1 regs: col[2:0], glyph_on, video_on.
  - Edge t+1: ROM returns rom_data. Stage-2 regs copy stage-1 sideband.
  - Edge t+2: rgb_text <= (s2_video_on & s2_glyph_on & rom_data[7-s2_col] & ~blank) ? {c[0],c[1],c[2]} : 3'b000, where c = active colour.
  - Fixed latency: inputs sampled at edge t appear on rgb_text after edge t+2. The sync generator delays hsync/vsync by 2 clocks to match.
- frame_start: registered pulse; 1 for exactly one cycle after the edge where (pixel_x,pixel_y)=(0,0) is first seen. Not re-asserted while (0,0) is held across pixel_tick-stretched cycles; re-arms when the coordinate leaves (0,0).
- Colour FSM:
  - IDLE: cfg_load -> pending<=sw_rgb, go ARMED.
  - ARMED: cfg_load -> pending<=sw_rgb (last wins), stay ARMED; frame_start -> go APPLY. If cfg_load and frame_start coincide, the new sw_rgb is captured and APPLY still follows.
  - APPLY: active<=pending for one cycle, go IDLE. A cfg_load during APPLY is captured to pending and next state is ARMED.
  - cfg_pending = (state != IDLE).
  - Active colour never changes mid-frame.
- Blink:
  - On frame_start: if counter == BLINK_FRAMES-1 then counter<=0 and blink_phase toggles; else counter++.
  - blank = blink_en & blink_phase.
  - Counter runs regardless of blink_en.
- Reset mid-frame or mid-FSM: all state returns to reset values on the next edge; the pipeline flushes and rgb_text=0 for at least 2 cycles after rst deasserts.
- pixel_x < X0 never wraps into the span (unsigned compare is done before subtraction).

Test Plan:
- Reset release, pixel (303,232), video_on=1, rom_data=8'h80 at t+1 -> rom_addr=6'h10 after edge t; rgb_text=3'b111 after edge t+2.
- Sweep x=300..340 at y=240, ROM model with all bits set -> rom_addr char field 0,1,2,3 at x 310/311, 322/323, 334/335 boundaries; rgb_text black at x 311-314, 323-326, 335.
- video_on=0 inside glyph, rom_data=8'hFF -> rgb_text=000. y=248 -> rom_addr=0, black.
- sw_rgb=3'b001, cfg_load pulse mid-frame -> cfg_pending=1, colour unchanged until frame_start. Cycle after APPLY: lit pixels = 3'b100, cfg_pending=0. Second cfg_load with sw_rgb=3'b010 before frame_start -> 3'b010 applied.
- blink_en=1, BLINK_FRAMES=2, 8 frames -> text visible frames 0-1, blank 2-3, visible 4-5, blank 6-7.
- rst asserted while ARMED with pending=3'b011 -> after release cfg_pending=0, colour 3'b111, rgb_text=0 for 2 cycles.

Source files
------------

// File: rtl/text_render_ctrl.sv
// -----------------------------------------------------------------------------
// text_render_ctrl
//   Sequencing controller for the on-screen "ISA" text overlay. Maps the VGA
//   pixel coordinate onto a glyph cell, addresses the synchronous font ROM,
//   re-aligns the returned glyph row with the delayed pixel sideband, and
//   colours the lit pixels. The text colour is reloaded only on a frame
//   boundary, and the text can optionally blink with a frame-based period.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   video_on     visible-area flag from the sync generator
//   pixel_x/y    current pixel column / row (10 bits each)
//   sw_rgb       colour switches {blue,green,red}
//   cfg_load     one-cycle request to load sw_rgb as the next text colour
//   blink_en     level enable for text blink
//   rom_addr     font ROM address {char_code[1:0], row[3:0]}
//   rom_data     font ROM word, bit 7 is the leftmost pixel (1-cycle latency)
//   rgb_text     pixel colour {red,green,blue}, 2 clocks after the coordinate
//   frame_start  one-cycle pulse after pixel (0,0) is first seen
//   cfg_pending  high while a colour load waits to be applied
// -----------------------------------------------------------------------------
module text_render_ctrl #(
  parameter int X0           = 303,
  parameter int Y0           = 232,
  parameter int CHAR_W       = 8,
  parameter int GAP          = 4,
  parameter int CHAR_H       = 16,
  parameter int STR_LEN      = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [2:0] sw_rgb,
  input  logic       cfg_load,
  input  logic       blink_en,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [2:0] rgb_text,
  output logic       frame_start,
  output logic       cfg_pending
);

  localparam int PITCH = CHAR_W + GAP;
  localparam int SPAN  = STR_LEN * PITCH;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  // ---------------- geometry ----------------
  logic [9:0] dx, idx, col;
  logic       in_band, in_span, glyph_on;
  logic [1:0] char_code;
  logic [3:0] row;

  always_comb begin
    dx       = pixel_x - 10'(X0);
    in_band  = (pixel_y >= 10'(Y0)) && (pixel_y <= 10'(Y0 + CHAR_H - 1));
    // The pixel_x >= X0 term keeps columns left of X0 (where dx wraps to a
    // large value) out of the span.
    in_span  = (pixel_x >= 10'(X0)) && (dx < 10'(SPAN));
    idx      = dx / 10'(PITCH);
    col      = dx % 10'(PITCH);
    glyph_on = in_band && in_span && (col < 10'(CHAR_W));
    char_code = glyph_on ? 2'(idx + 10'd1) : 2'd0;
    row       = in_band ? 4'(pixel_y - 10'(Y0)) : 4'd0;
  end

  // ---------------- registers ----------------
  logic [5:0] rom_addr_q;
  logic [2:0] s1_col_q, s2_col_q;
  logic       s1_glyph_on_q, s2_glyph_on_q;
  logic       s1_video_on_q, s2_video_on_q;
  logic [2:0] rgb_text_q, rgb_text_d;
  logic       origin_seen_q, frame_start_q;
  logic [1:0] state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] active_q, active_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  logic at_origin;
  assign at_origin = (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // ---------------- colour FSM ----------------
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          pending_d = sw_rgb;
          state_d   = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A load coinciding with frame_start is captured and still applied.
        if (cfg_load) pending_d = sw_rgb;
        if (frame_start_q) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        active_d = pending_q;
        state_d  = ST_IDLE;
        if (cfg_load) begin
          pending_d = sw_rgb;
          state_d   = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- blink ----------------
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start_q) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  logic blank;
  assign blank = blink_en & blink_phase_q;

  // Output colour bus is the bit-reverse of the switch ordering.
  logic [2:0] colour_rgb;
  for (genvar gi = 0; gi < 3; gi++) begin : g_colour_swap
    assign colour_rgb[gi] = active_q[2-gi];
  end

  // ---------------- output stage ----------------
  logic lit;
  always_comb begin
    lit        = s2_video_on_q & s2_glyph_on_q & rom_data[3'd7 - s2_col_q] & ~blank;
    rgb_text_d = lit ? colour_rgb : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q    <= '0;
      s1_col_q      <= '0;
      s1_glyph_on_q <= 1'b0;
      s1_video_on_q <= 1'b0;
      s2_col_q      <= '0;
      s2_glyph_on_q <= 1'b0;
      s2_video_on_q <= 1'b0;
      rgb_text_q    <= '0;
      origin_seen_q <= 1'b0;
      frame_start_q <= 1'b0;
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      active_q      <= 3'b111;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      rom_addr_q    <= {char_code, row};
      s1_col_q      <= col[2:0];
      s1_glyph_on_q <= glyph_on;
      s1_video_on_q <= video_on;
      s2_col_q      <= s1_col_q;
      s2_glyph_on_q <= s1_glyph_on_q;
      s2_video_on_q <= s1_video_on_q;
      rgb_text_q    <= rgb_text_d;
      // Pulse only on entry to (0,0) so a stretched origin pixel fires once.
      origin_seen_q <= at_origin;
      frame_start_q <= at_origin & ~origin_seen_q;
      state_q       <= state_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rgb_text    = rgb_text_q;
  assign frame_start = frame_start_q;
  assign cfg_pending = (state_q != ST_IDLE);

endmodule

// File: tb/tb_text_render_ctrl.sv
// -----------------------------------------------------------------------------
// tb_text_render_ctrl
//   Scoreboard bench for text_render_ctrl. A driver issues compressed frames
//   (origin pixel, then directed or random coordinates) and a reference model
//   computes the expected ROM address, frame_start, cfg_pending and pixel
//   colour for each coordinate; a separate monitor pops and compares them when
//   the corresponding output is due. The font ROM is modelled with one cycle
//   of read latency.
// -----------------------------------------------------------------------------
module tb_text_render_ctrl;

  localparam int X0      = 303;
  localparam int Y0      = 232;
  localparam int CHAR_W  = 8;
  localparam int GAP     = 4;
  localparam int CHAR_H  = 16;
  localparam int STR_LEN = 3;
  localparam int BF      = 2;
  localparam int PITCH   = CHAR_W + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [2:0] sw_rgb = '0;
  logic       cfg_load = 1'b0;
  logic       blink_en = 1'b0;
  logic [5:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [2:0] rgb_text;
  logic       frame_start;
  logic       cfg_pending;

  always #5 clk = ~clk;

  text_render_ctrl #(.BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .sw_rgb     (sw_rgb),
    .cfg_load   (cfg_load),
    .blink_en   (blink_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb_text   (rgb_text),
    .frame_start(frame_start),
    .cfg_pending(cfg_pending)
  );

  // Font ROM model: synchronous, one cycle latency.
  logic [7:0] font_mem [64];
  always @(posedge clk) rom_data <= font_mem[rom_addr];

  // ---------------- scoreboard ----------------
  typedef struct { int tag; int x; int y; logic [5:0] addr; logic fs; logic pend; } a_ent_t;
  typedef struct { int tag; int x; int y; logic [2:0] rgb; } r_ent_t;
  a_ent_t aq[$];
  r_ent_t rq[$];

  int   edge_cnt = 0;
  logic rst_smp  = 1'b0;
  int   rel_edge = -100;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_smp  <= rst;
  end

  task automatic check(input string name, input int x, input int y, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at (%0d,%0d): got %0h, expected %0h", name, x, y, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [2:0] m_active  = 3'b111;
  logic [2:0] m_pending = 3'b000;
  bit         m_armed   = 1'b0;
  int         m_hold    = 0;
  int         m_frames  = 0;
  bit         m_prev00  = 1'b0;
  bit         blink_lvl = 1'b0;

  function automatic logic [5:0] exp_addr(input int x, input int y);
    int code, rw, d;
    code = 0;
    rw   = 0;
    if (y >= Y0 && y <= Y0 + CHAR_H - 1) begin
      rw = y - Y0;
      if (x >= X0) begin
        d = x - X0;
        if (d < STR_LEN * PITCH && (d % PITCH) < CHAR_W) code = d / PITCH + 1;
      end
    end
    return 6'(code * 16 + rw);
  endfunction

  function automatic logic [2:0] exp_rgb(input int x, input int y, input bit vo,
                                         input logic [2:0] act, input bit blank);
    logic [5:0] a;
    logic [7:0] b;
    int c;
    a = exp_addr(x, y);
    if (!vo || blank || a[5:4] == 2'd0) return 3'b000;
    b = font_mem[a];
    c = (x - X0) % PITCH;
    if (b[7-c]) return {act[0], act[1], act[2]};
    return 3'b000;
  endfunction

  task automatic drive_px(input int x, input int y, input bit vo, input bit load, input logic [2:0] sw);
    bit is00, fs, pend, blank;
    a_ent_t a;
    r_ent_t r;
    is00 = (x == 0 && y == 0);
    fs   = is00 && !m_prev00;
    if (fs) m_frames++;
    if (fs && m_armed) begin
      m_active = m_pending;
      m_armed  = 1'b0;
      m_hold   = 1;
      pend     = 1'b1;
    end else if (m_hold > 0) begin
      pend = 1'b1;
      m_hold--;
    end else begin
      pend = m_armed;
    end
    if (load) begin
      m_pending = sw;
      m_armed   = 1'b1;
      pend      = 1'b1;
    end
    m_prev00 = is00;
    blank = blink_lvl && (((m_frames / BF) % 2) == 1);

    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = vo;
    cfg_load = load;
    sw_rgb   = sw;
    blink_en = blink_lvl;

    a.tag = edge_cnt + 1; a.x = x; a.y = y;
    a.addr = exp_addr(x, y); a.fs = fs; a.pend = pend;
    r.tag = edge_cnt + 1; r.x = x; r.y = y;
    r.rgb = exp_rgb(x, y, vo, m_active, blank);
    aq.push_back(a);
    rq.push_back(r);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    cfg_load = 1'b0;
    pixel_x  = 10'd303;
    pixel_y  = 10'd232;
    video_on = 1'b1;
    aq.delete();
    rq.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst       = 1'b0;
    rel_edge  = edge_cnt + 1;
    m_active  = 3'b111;
    m_pending = 3'b000;
    m_armed   = 1'b0;
    m_hold    = 0;
    m_frames  = 0;
    m_prev00  = 1'b0;
  endtask

  // mode 0: directed sweep, 2: two loads (last wins), 3: load then reset, else random
  task automatic run_frame(input int mode, input int n_rand, input bit blink);
    int hold_n, x, y;
    bit vo, ld;
    blink_lvl = blink;
    hold_n = $urandom_range(1, 3);
    for (int h = 0; h < hold_n; h++) drive_px(0, 0, 1'b1, 1'b0, 3'd0);
    drive_px(5, 0, 1'b1, 1'b0, 3'd0);
    drive_px(6, 0, 1'b1, 1'b0, 3'd0);
    case (mode)
      0: begin
        for (int xx = 300; xx <= 340; xx++) drive_px(xx, 240, 1'b1, 1'b0, 3'd0);
        drive_px(303, 232, 1'b1, 1'b0, 3'd0);
        drive_px(310, 247, 1'b1, 1'b0, 3'd0);
        drive_px(305, 240, 1'b0, 1'b0, 3'd0);
        drive_px(305, 248, 1'b1, 1'b0, 3'd0);
        drive_px(305, 231, 1'b1, 1'b0, 3'd0);
        drive_px(302, 232, 1'b1, 1'b0, 3'd0);
      end
      2: begin
        for (int k = 0; k < 20; k++)
          drive_px(303 + (k % 32), 232 + (k % 16), 1'b1, (k == 5) || (k == 15),
                   (k == 5) ? 3'b001 : 3'b010);
      end
      3: begin
        for (int k = 0; k < 12; k++) drive_px(303 + k, 236, 1'b1, k == 3, 3'b011);
        do_reset(2);
        for (int k = 0; k < 4; k++) drive_px(303 + k, 236, 1'b1, 1'b0, 3'b000);
      end
      default: begin
        for (int k = 0; k < n_rand; k++) begin
          if ($urandom_range(0, 9) < 7) begin
            x = $urandom_range(296, 342);
            y = $urandom_range(228, 251);
          end else begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            if (x == 0 && y == 0) x = 1;
          end
          vo = ($urandom_range(0, 7) != 0);
          ld = ($urandom_range(0, 19) == 0);
          drive_px(x, y, vo, ld, 3'($urandom));
        end
      end
    endcase
    drive_px(600, 470, 1'b1, 1'b0, 3'd0);
    drive_px(600, 470, 1'b1, 1'b0, 3'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    a_ent_t a;
    r_ent_t r;
    if (rst_smp) begin
      check("reset_rom_addr", -1, -1, int'(rom_addr), 0);
      check("reset_rgb_text", -1, -1, int'(rgb_text), 0);
      check("reset_frame_start", -1, -1, int'(frame_start), 0);
      check("reset_cfg_pending", -1, -1, int'(cfg_pending), 0);
    end else begin
      if (edge_cnt == rel_edge || edge_cnt == rel_edge + 1)
        check("flush_rgb_text", -1, -1, int'(rgb_text), 0);
      while (aq.size() > 0 && aq[0].tag <= edge_cnt) begin
        a = aq.pop_front();
        if (a.tag == edge_cnt) begin
          check("rom_addr", a.x, a.y, int'(rom_addr), int'(a.addr));
          check("frame_start", a.x, a.y, int'(frame_start), int'(a.fs));
          check("cfg_pending", a.x, a.y, int'(cfg_pending), int'(a.pend));
        end
      end
      while (rq.size() > 0 && rq[0].tag + 2 <= edge_cnt) begin
        r = rq.pop_front();
        if (r.tag + 2 == edge_cnt) begin
          check("rgb_text", r.x, r.y, int'(rgb_text), int'(r.rgb));
          $display("px (%0d,%0d) rgb_text=%b model=%b", r.x, r.y, rgb_text, r.rgb);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) font_mem[i] = 8'hFF;
    do_reset(3);
    run_frame(0, 0, 1'b0);                      // geometry sweep, all pixels set
    run_frame(2, 0, 1'b0);                      // loads 001 then 010
    run_frame(0, 0, 1'b0);                      // 010 now active
    for (int i = 0; i < 64; i++) font_mem[i] = 8'($urandom);
    for (int f = 0; f < 8; f++) run_frame(1, 30, 1'b1);   // blink pattern
    for (int f = 0; f < 16; f++) run_frame(1, 40, ($urandom_range(0, 3) != 0));
    run_frame(3, 0, 1'b0);                      // reset while a load is armed
    for (int f = 0; f < 4; f++) run_frame(1, 30, 1'b1);

    for (int i = 0; i < 10 && (aq.size() > 0 || rq.size() > 0); i++) @(posedge clk);
    #1;
    check("drain_queues", -1, -1, aq.size() + rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
